// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg
// Shared types and constants for the USB CRC-5/CRC-16 receive checker.
//   - crc_mode_e  : which CRC the current packet uses (token vs data)
//   - crc_state_e : checker FSM states
//   - polynomials, preload values and good-packet residuals, plus small
//     helpers that select them by mode.
// CRC-5 values live in the low 5 bits of the shared 16-bit register.
package usb_crc_pkg;

  typedef enum logic {
    CRC_MODE_5  = 1'b0,
    CRC_MODE_16 = 1'b1
  } crc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'h0C;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  function automatic int crc_width(input crc_mode_e mode);
    return (mode == CRC_MODE_16) ? 16 : 5;
  endfunction

  function automatic logic [15:0] crc_init(input crc_mode_e mode);
    return (mode == CRC_MODE_16) ? CRC16_INIT : {11'b0, CRC5_INIT};
  endfunction

  function automatic logic [15:0] crc_resid(input crc_mode_e mode);
    return (mode == CRC_MODE_16) ? CRC16_RESID : {11'b0, CRC5_RESID};
  endfunction

endpackage

// File: rtl/usb_crc_step.sv
// usb_crc_step
// Combinational DIN_W-bit unrolled LFSR update for the USB CRCs.
// Ports:
//   crc_in  [15:0]    current CRC register (CRC-5 uses bits [4:0])
//   mode              CRC_MODE_5 or CRC_MODE_16
//   data    [DIN_W-1] received bits, data[0] arrived first on the wire
//   crc_out [15:0]    register after absorbing all DIN_W bits
module usb_crc_step
  import usb_crc_pkg::*;
#(
  parameter int DIN_W = 1
) (
  input  logic [15:0]      crc_in,
  input  crc_mode_e        mode,
  input  logic [DIN_W-1:0] data,
  output logic [15:0]      crc_out
);

  logic [15:0] crc_v;
  logic        fb;

  // Serial CRC step applied once per bit, oldest bit first. In CRC-5 mode
  // the upper 11 bits are forced to zero so the shared register compares
  // cleanly against the zero-extended residual.
  always_comb begin
    crc_v = crc_in;
    fb    = 1'b0;
    for (int i = 0; i < DIN_W; i++) begin
      if (mode == CRC_MODE_16) begin
        fb    = crc_v[15] ^ data[i];
        crc_v = {crc_v[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end else begin
        fb    = crc_v[4] ^ data[i];
        crc_v = {11'b0, crc_v[3:0], 1'b0} ^ (fb ? {11'b0, CRC5_POLY} : 16'h0000);
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/usb_crc_checker.sv
// usb_crc_checker
// Multi-bit-per-cycle USB CRC-5/CRC-16 receive checker with packet framing.
// Optional feature macro: USB_CRC_ERRCNT_EN adds the err_count output.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   crc_clear     start of packet: preload CRC, zero counter, enter RUN
//   shift_enable  d_orig beat valid (qualified by crc_enable)
//   d_orig        DIN_W received bits, bit 0 first on the wire
//   packet_type   0 = CRC-5 token, 1 = CRC-16 data; sampled at crc_clear
//   crc_enable    beats with crc_enable=0 are ignored
//   eop           end of packet, triggers the residual check
//   crc_done      one-cycle strobe, crc_check/crc_short valid
//   crc_check     residual matched (held until next crc_clear)
//   crc_short     packet shorter than the CRC width
//   bit_count     saturating count of bits absorbed this packet
//   err_count     failed packets, saturating (USB_CRC_ERRCNT_EN only)
module usb_crc_checker
  import usb_crc_pkg::*;
#(
  parameter int DIN_W = 1,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crc_clear,
  input  logic             shift_enable,
  input  logic [DIN_W-1:0] d_orig,
  input  logic             packet_type,
  input  logic             crc_enable,
  input  logic             eop,
  output logic             crc_done,
  output logic             crc_check,
  output logic             crc_short,
`ifdef USB_CRC_ERRCNT_EN
  output logic [CNT_W-1:0] bit_count,
  output logic [7:0]       err_count
`else
  output logic [CNT_W-1:0] bit_count
`endif
);

  crc_state_e       state_q, state_d;
  crc_mode_e        mode_q, mode_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             check_q, check_d;
  logic             short_q, short_d;
`ifdef USB_CRC_ERRCNT_EN
  logic [7:0]       err_q, err_d;
`endif

  logic             absorb;
  logic [15:0]      crc_stepped;
  logic [15:0]      crc_post;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_post;

  usb_crc_step #(
    .DIN_W(DIN_W)
  ) u_step (
    .crc_in (crc_q),
    .mode   (mode_q),
    .data   (d_orig),
    .crc_out(crc_stepped)
  );

  // The register and counter values after this cycle's beat (if any).
  // The eop check compares these so a beat arriving with eop counts.
  always_comb begin
    absorb   = (state_q == ST_RUN) && shift_enable && crc_enable;
    cnt_sum  = {1'b0, cnt_q} + (CNT_W + 1)'(DIN_W);
    cnt_inc  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    crc_post = absorb ? crc_stepped : crc_q;
    cnt_post = absorb ? cnt_inc : cnt_q;
  end

  // Next-state logic. crc_clear overrides everything, including an eop in
  // the same cycle, so a clear+eop produces no done strobe.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    check_d = check_q;
    short_d = short_q;
`ifdef USB_CRC_ERRCNT_EN
    err_d   = err_q;
`endif
    if (crc_clear) begin
      state_d = ST_RUN;
      mode_d  = crc_mode_e'(packet_type);
      crc_d   = crc_init(crc_mode_e'(packet_type));
      cnt_d   = '0;
      check_d = 1'b0;
      short_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      crc_d = crc_post;
      cnt_d = cnt_post;
      if (eop) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        short_d = int'(cnt_post) < crc_width(mode_q);
        check_d = (int'(cnt_post) >= crc_width(mode_q)) &&
                  (crc_post == crc_resid(mode_q));
`ifdef USB_CRC_ERRCNT_EN
        if (!check_d && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
`endif
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= CRC_MODE_5;
      crc_q   <= CRC16_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      check_q <= 1'b0;
      short_q <= 1'b0;
`ifdef USB_CRC_ERRCNT_EN
      err_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      check_q <= check_d;
      short_q <= short_d;
`ifdef USB_CRC_ERRCNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign crc_done  = done_q;
  assign crc_check = check_q;
  assign crc_short = short_q;
  assign bit_count = cnt_q;
`ifdef USB_CRC_ERRCNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_usb_crc_checker.sv
// tb_usb_crc_checker
// Self-checking bench for usb_crc_checker. Two instances are exercised:
// a serial one (DIN_W=1) and a byte-wide one (DIN_W=8). Expected results
// are queued when eop is driven and compared when crc_done fires.
module tb_usb_crc_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // serial instance
  logic        clr1, se1, pt1, en1, eop1;
  logic [0:0]  d1;
  logic        done1, chk1, sh1;
  logic [10:0] cnt1;
  // byte-wide instance
  logic        clr8, se8, pt8, en8, eop8;
  logic [7:0]  d8;
  logic        done8, chk8, sh8;
  logic [10:0] cnt8;
`ifdef USB_CRC_ERRCNT_EN
  logic [7:0]  err1, err8;
`endif

  usb_crc_checker #(.DIN_W(1), .CNT_W(11)) u_dut1 (
    .clk(clk), .rst(rst), .crc_clear(clr1), .shift_enable(se1), .d_orig(d1),
    .packet_type(pt1), .crc_enable(en1), .eop(eop1), .crc_done(done1),
    .crc_check(chk1), .crc_short(sh1),
`ifdef USB_CRC_ERRCNT_EN
    .bit_count(cnt1), .err_count(err1)
`else
    .bit_count(cnt1)
`endif
  );

  usb_crc_checker #(.DIN_W(8), .CNT_W(11)) u_dut8 (
    .clk(clk), .rst(rst), .crc_clear(clr8), .shift_enable(se8), .d_orig(d8),
    .packet_type(pt8), .crc_enable(en8), .eop(eop8), .crc_done(done8),
    .crc_check(chk8), .crc_short(sh8),
`ifdef USB_CRC_ERRCNT_EN
    .bit_count(cnt8), .err_count(err8)
`else
    .bit_count(cnt8)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic check;
    logic shrt;
    int   count;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t m1, m8;

  // Reference CRC step, one bit at a time.
  function automatic logic [15:0] model_step(input logic [15:0] c, input logic b, input logic m16);
    logic fb;
    if (m16) begin
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    fb = c[4] ^ b;
    return {11'b0, c[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
  endfunction

  // Scoreboards: every crc_done pops one expected result.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      tests_run++;
      if (q1.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL dut1_unexpected_done check=%0b short=%0b count=%0d, expected no done", chk1, sh1, cnt1);
      end else begin
        m1 = q1.pop_front();
        if (chk1 !== m1.check || sh1 !== m1.shrt || cnt1 !== 11'(m1.count)) begin
          tests_failed++;
          $display("[TB] FAIL dut1_result got check=%0b short=%0b count=%0d, expected check=%0b short=%0b count=%0d",
                   chk1, sh1, cnt1, m1.check, m1.shrt, m1.count);
        end
      end
    end
    if (done8 === 1'b1) begin
      tests_run++;
      if (q8.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL dut8_unexpected_done check=%0b short=%0b count=%0d, expected no done", chk8, sh8, cnt8);
      end else begin
        m8 = q8.pop_front();
        if (chk8 !== m8.check || sh8 !== m8.shrt || cnt8 !== 11'(m8.count)) begin
          tests_failed++;
          $display("[TB] FAIL dut8_result got check=%0b short=%0b count=%0d, expected check=%0b short=%0b count=%0d",
                   chk8, sh8, cnt8, m8.check, m8.shrt, m8.count);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear1(input logic pt);
    clr1 = 1'b1; pt1 = pt; tick(); clr1 = 1'b0;
  endtask

  task automatic clear8(input logic pt);
    clr8 = 1'b1; pt8 = pt; tick(); clr8 = 1'b0;
  endtask

  task automatic beat1(input logic b, input logic with_eop);
    se1 = 1'b1; en1 = 1'b1; d1 = b; eop1 = with_eop; tick();
    se1 = 1'b0; eop1 = 1'b0;
  endtask

  task automatic beat8(input logic [7:0] b, input logic with_eop);
    se8 = 1'b1; en8 = 1'b1; d8 = b; eop8 = with_eop; tick();
    se8 = 1'b0; eop8 = 1'b0;
  endtask

  task automatic eop_only1();
    eop1 = 1'b1; tick(); eop1 = 1'b0;
  endtask

  task automatic push1(input logic c, input logic s, input int n);
    exp_t e;
    e.check = c; e.shrt = s; e.count = n;
    q1.push_back(e);
  endtask

  task automatic push8(input logic c, input logic s, input int n);
    exp_t e;
    e.check = c; e.shrt = s; e.count = n;
    q8.push_back(e);
  endtask

  // Bounded wait for the scoreboards to drain; done must follow eop by one cycle.
  task automatic await_done(input string name);
    int k = 0;
    while ((q1.size() != 0 || q8.size() != 0) && k < 8) begin
      @(negedge clk); #1; k++;
    end
    tests_run++;
    if (q1.size() != 0 || q8.size() != 0 || k != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_done_latency got %0d cycles (pending %0d/%0d), expected 1 cycle", name, k, q1.size(), q8.size());
      q1.delete(); q8.delete();
    end
  endtask

  // Token ADDR/ENDP LSB-first followed by the 5-bit CRC field MSB-first.
  function automatic logic [15:0] token_bits(input logic [6:0] addr, input logic [3:0] endp, input logic [4:0] crcf);
    logic [15:0] w;
    for (int i = 0; i < 7; i++) w[i] = addr[i];
    for (int i = 0; i < 4; i++) w[7 + i] = endp[i];
    for (int i = 0; i < 5; i++) w[11 + i] = crcf[4 - i];
    return w;
  endfunction

  logic [15:0] good_tok;

  task automatic send_token1(input logic [15:0] w, input logic eop_with_last);
    for (int i = 0; i < 16; i++) beat1(w[i], eop_with_last && (i == 15));
    if (!eop_with_last) eop_only1();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if ({done1, chk1, sh1, cnt1} !== 14'd0 || {done8, chk8, sh8, cnt8} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got dut1=%0b%0b%0b/%0d dut8=%0b%0b%0b/%0d, expected all zero",
               done1, chk1, sh1, cnt1, done8, chk8, sh8, cnt8);
    end
`ifdef USB_CRC_ERRCNT_EN
    tests_run++;
    if (err1 !== 8'd0 || err8 !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_err_count got %0d/%0d, expected 0/0", err1, err8);
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_token_good();
    clear1(1'b0);
    push1(1'b1, 1'b0, 16);
    send_token1(good_tok, 1'b0);
    await_done("token_good");
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if (chk1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL check_held got %0b, expected 1", chk1);
    end
    tick();
    eop_only1();
    @(negedge clk);
    tests_run++;
    if (done1 !== 1'b0 || chk1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL eop_in_done got done=%0b check=%0b, expected done=0 check=1", done1, chk1);
    end
    tick();
  endtask

  task automatic test_token_bad();
    logic [15:0] w;
    w = good_tok;
    w[3] = ~w[3];
    clear1(1'b0);
    push1(1'b0, 1'b0, 16);
    send_token1(w, 1'b0);
    await_done("token_bad");
`ifdef USB_CRC_ERRCNT_EN
    tests_run++;
    if (err1 !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL err_count_bad got %0d, expected 1", err1);
    end
`endif
  endtask

  task automatic test_short();
    clear1(1'b1);
    for (int i = 0; i < 8; i++) beat1(1'b0, 1'b0);
    push1(1'b0, 1'b1, 8);
    eop_only1();
    await_done("short");
  endtask

  task automatic test_crc16_zero_len();
    clear8(1'b1);
    clear1(1'b1);
    beat8(8'h00, 1'b0);
    push8(1'b1, 1'b0, 16);
    beat8(8'h00, 1'b1);
    await_done("zlp_w8");
    for (int i = 0; i < 15; i++) beat1(1'b0, 1'b0);
    push1(1'b1, 1'b0, 16);
    beat1(1'b0, 1'b1);
    await_done("zlp_w1");
  endtask

  task automatic test_eop_with_last_beat();
    clear1(1'b0);
    push1(1'b1, 1'b0, 16);
    send_token1(good_tok, 1'b1);
    await_done("eop_last_beat");
  endtask

  task automatic test_clear_with_eop();
    // dut1 sits in DONE with check=1 from the previous test
    clr1 = 1'b1; eop1 = 1'b1; pt1 = 1'b0;
    tick();
    clr1 = 1'b0; eop1 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done1 !== 1'b0 || chk1 !== 1'b0 || cnt1 !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_with_eop got done=%0b check=%0b count=%0d, expected 0 0 0", done1, chk1, cnt1);
    end
    tick();
    // no further clear: the checker must already be in RUN
    push1(1'b1, 1'b0, 16);
    send_token1(good_tok, 1'b1);
    await_done("after_clear_eop");
  endtask

  task automatic test_random_crc16();
    logic [31:0] bits;
    logic [15:0] c;
    for (int it = 0; it < 3; it++) begin
      bits[15:0] = 16'($urandom);
      c = 16'hFFFF;
      for (int i = 0; i < 16; i++) c = model_step(c, bits[i], 1'b1);
      for (int i = 0; i < 16; i++) bits[16 + i] = ~c[15 - i];
      clear1(1'b1);
      clear8(1'b1);
      for (int b = 0; b < 3; b++) beat8(bits[8*b +: 8], 1'b0);
      push8(1'b1, 1'b0, 32);
      beat8(bits[31:24], 1'b1);
      await_done("rand_w8");
      for (int i = 0; i < 31; i++) beat1(bits[i], 1'b0);
      push1(1'b1, 1'b0, 32);
      beat1(bits[31], 1'b1);
      await_done("rand_w1");
    end
  endtask

  task automatic test_saturation();
    logic [15:0] c;
    logic [7:0]  b;
    clear8(1'b1);
    c = 16'hFFFF;
    for (int k = 0; k < 258; k++) begin
      b = 8'($urandom);
      for (int j = 0; j < 8; j++) c = model_step(c, b[j], 1'b1);
      beat8(b, 1'b0);
    end
    b = 8'h00;
    for (int j = 0; j < 8; j++) b[j] = ~c[15 - j];
    beat8(b, 1'b0);
    for (int j = 0; j < 8; j++) c = model_step(c, b[j], 1'b1);
    for (int j = 0; j < 8; j++) b[j] = ~c[7 - j];
    for (int j = 0; j < 8; j++) c = model_step(c, b[j], 1'b1);
    push8(c == 16'h800D, 1'b0, 2047);
    beat8(b, 1'b1);
    await_done("saturation");
  endtask

  task automatic test_rst_mid_packet();
    clear1(1'b0);
    for (int i = 0; i < 6; i++) beat1(good_tok[i], 1'b0);
    rst = 1'b1;
    se1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
    tick();
    rst = 1'b0; se1 = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({done1, chk1, sh1, cnt1} !== 14'd0 || {done8, chk8, sh8, cnt8} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_packet got dut1=%0b%0b%0b/%0d dut8=%0b%0b%0b/%0d, expected all zero",
               done1, chk1, sh1, cnt1, done8, chk8, sh8, cnt8);
    end
`ifdef USB_CRC_ERRCNT_EN
    tests_run++;
    if (err1 !== 8'd0 || err8 !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_err_count got %0d/%0d, expected 0/0", err1, err8);
    end
`endif
    tick();
    clear1(1'b0);
    push1(1'b1, 1'b0, 16);
    send_token1(good_tok, 1'b0);
    await_done("after_rst");
  endtask

  initial begin
    rst = 1'b1;
    clr1 = 0; se1 = 0; pt1 = 0; en1 = 0; eop1 = 0; d1 = '0;
    clr8 = 0; se8 = 0; pt8 = 0; en8 = 0; eop8 = 0; d8 = '0;
    good_tok = token_bits(7'h15, 4'hE, 5'b10111);
    test_reset();
    test_token_good();
    test_token_bad();
    test_short();
    test_crc16_zero_len();
    test_eop_with_last_beat();
    test_clear_with_eop();
    test_random_crc16();
    test_saturation();
    test_rst_mid_packet();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/usb_crc_checker.md
# usb_crc_checker

Parametrised successor to the dual-mode USB CRC checker. It is a multi-bit-per-cycle CRC-5/CRC-16 receive checker with explicit packet framing, a bit counter and a short-packet flag. It sits between the bit-unstuffing/shift stage and the RX packet controller. It runs a residual check when end-of-packet arrives and reports a registered pass/fail with a one-cycle done strobe.

## Interface
Parameters:
- DIN_W, 1: bits accepted per shift_enable beat (1, 2, 4 or 8).
- CNT_W, 11: bit-counter width (saturating).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- crc_clear  in  1  start of packet: preload the CRC, zero the counter, enter RUN.
- shift_enable  in  1  d_orig beat valid.
- d_orig  in  DIN_W  received bits; bit 0 arrived first on the wire.
- packet_type  in  1  0 = CRC-5 (token), 1 = CRC-16 (data); sampled at crc_clear.
- crc_enable  in  1  qualifies shift_enable; beats with crc_enable=0 are ignored.
- eop  in  1  end of packet; triggers the check.
- crc_done  out  1  one-cycle strobe; crc_check/crc_short are valid.
- crc_check  out  1  1 = residual matched, held until the next crc_clear.
- crc_short  out  1  1 = packet had fewer bits than the CRC width.
- bit_count  out  CNT_W  bits absorbed this packet.
- err_count  out  8  only when USB_CRC_ERRCNT_EN is defined.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on crc_clear.
  - RUN→DONE on eop.
  - DONE→RUN on crc_clear.
  - DONE holds otherwise.
  - eop in IDLE or DONE is ignored.
- crc_clear has priority over eop and beats in every state. It loads the register with all ones (5'h1F or 16'hFFFF), latches packet_type into mode_q and zeroes bit_count.
- Beat absorbed when state==RUN && shift_enable && crc_enable. Bits are processed d_orig[0] first, DIN_W steps unrolled in one cycle.
- Per-bit step, W = 5 or 16 by mode_q: fb = crc[W-1] ^ d; crc = {crc[W-2:0],1'b0} ^ (fb ? POLY : 0).
  - POLY: 5'h05 for CRC-5, 16'h8005 for CRC-16.
  - The CRC-5 path uses the low 5 bits of the shared 16-bit register; upper bits are held at 0.
- The received CRC field is shifted through like data. Pass when the final register equals the residual: 5'h0C for CRC-5, 16'h800D for CRC-16.
- crc_short = bit_count_final < W. When crc_short is 1, crc_check is forced to 0.
- bit_count increments by DIN_W per absorbed beat and saturates at 2^CNT_W−1. Saturation does not affect the check.
- Packet length must be a multiple of DIN_W. A partial final beat is not supported.

## Timing
- Reset values: state IDLE, crc_done 0, crc_check 0, crc_short 0, bit_count 0, CRC register all ones, err_count 0.
- Beat absorbed at edge N is reflected in bit_count after edge N.
- eop sampled at edge N: crc_done=1 during cycle N+1 only; crc_check/crc_short are updated at edge N.
- eop together with an absorbed beat in the same cycle: the beat is absorbed first, and the comparison uses the post-beat register (next-state compare).
- crc_clear together with eop: the clear wins, no crc_done, and crc_check drops to 0.
- crc_clear in RUN abandons the packet silently. rst asserted mid-packet returns to reset values on the next edge.

## Configuration
- USB_CRC_ERRCNT_EN defined: err_count increments, saturating at 8'hFF, on each crc_done with crc_check=0. It is cleared only by rst.
- Macro undefined: the err_count port and its logic are absent.

## Structure
- Package usb_crc_pkg holds:
  - the mode enum (CRC_MODE_5, CRC_MODE_16);
  - the state enum;
  - the constants CRC5_POLY, CRC5_INIT, CRC5_RESID, CRC16_POLY, CRC16_INIT, CRC16_RESID.
- One sub-module, usb_crc_step: combinational, DIN_W-bit unrolled LFSR update taking crc_in, mode and data, producing crc_out. The top level owns the FSM, counter and outputs.

## Test plan
- CRC-5, DIN_W=1: token with ADDR=0x15, ENDP=0xE (11 bits, LSB-first) followed by CRC field 5'b10111, then eop → crc_done one cycle later, crc_check=1, bit_count=16.
- Same token with one data bit flipped → crc_check=0, crc_short=0. With USB_CRC_ERRCNT_EN defined, err_count=1.
- CRC-16, DIN_W=8: zero-length data packet, CRC bytes 0x00 0x00 → crc_check=1, bit_count=16. Repeat with DIN_W=1 and the same bits → identical result.
- CRC-16, eop asserted after 8 bits → crc_short=1, crc_check=0.
- eop on the same cycle as the last CRC beat → crc_check=1. crc_clear on the same cycle as eop → no crc_done, state RUN, bit_count=0.
- rst pulsed mid-packet, then a good token → all outputs 0 after the reset edge, and the subsequent packet passes.
